env_monitor_gen: RTL and testbench
==================================

# env_monitor_gen

Parametrised environment-monitor core for the temperature/humidity alarm panel. It debounces the humidity contact with a configurable depth and compares the temperature sample against hysteresis thresholds. It converts the sample to BCD with a sequential double-dabble engine, and runs a warning/alarm state machine with timed escalation and operator acknowledge. Its outputs feed the seven-segment multiplexer (BCD digits, status) and the panel LEDs.

## Interface
- DW, 7: temperature sample width, 4..13.
- DEB, 3: humidity debounce depth in clock cycles, ≥1.
- TEMP_HI, 35: T_flag set threshold; sample ≥ TEMP_HI sets.
- TEMP_LO, 32: T_flag clear threshold; sample < TEMP_LO clears. Must satisfy TEMP_LO ≤ TEMP_HI.
- ESC_CYCLES, 16: cycles in WARN before escalating to ALARM; also the COOLDOWN length. ≥1.

- clock  in  1  system clock. One clock; reset is synchronous and active-high.
- clr  in  1  synchronous active-high reset.
- temp_in  in  DW  unsigned temperature sample.
- sample_en  in  1  one-cycle strobe; capture temp_in.
- hu  in  1  raw humidity contact.
- ack  in  1  operator alarm acknowledge, level.
- T_flag  out  1  temperature-high flag with hysteresis.
- H_flag  out  1  debounced humidity flag.
- warning  out  1  high in WARN.
- alarm  out  1  high in ALARM.
- status  out  4  one-hot state: 0001 IDLE, 0010 WARN, 0100 ALARM, 1000 COOLDOWN.
- bcd  out  16  four BCD digits, thousands in [15:12], ones in [3:0].
- bcd_valid  out  1  one-cycle pulse when bcd updates.
- busy  out  1  converter running.

## Operation
- Reset (clr=1 at a clock edge) has the following values; it aborts any conversion or count mid-operation:
  - T_flag=0, H_flag=0, warning=0, alarm=0, status=0001.
  - bcd=0, bcd_valid=0, busy=0.
  - Debounce counter and escalation counter are cleared.
- Capture: sample_en=1 with busy=0 latches temp_in into the sample register and sets busy.
  - sample_en while busy=1 is ignored; there is no queueing.
- Hysteresis: evaluated on the captured sample, in the capture cycle.
  - Sample ≥ TEMP_HI: T_flag←1.
  - Sample < TEMP_LO: T_flag←0.
  - Otherwise T_flag holds its value.
- BCD: shift-add-3 double-dabble, one bit per cycle, DW iterations, MSB first.
  - At completion, bcd is loaded, bcd_valid pulses, busy drops.
  - bcd holds its value between conversions.
- Debounce: a counter tracks how long hu has differed from H_flag.
  - H_flag toggles once hu has differed from it for DEB consecutive cycles.
  - Any cycle with hu equal to H_flag resets the counter.
  - The debounce is symmetric on rise and fall.
- FSM (Moore; warning, alarm and status decode the state register):
  - IDLE: T_flag&H_flag→ALARM; T_flag^H_flag→WARN.
  - WARN: both flags→ALARM; neither flag→IDLE. Otherwise count; after ESC_CYCLES consecutive cycles in WARN→ALARM. The counter clears on entry.
  - ALARM: latched. ack=1 with both flags 0→COOLDOWN. ack with any flag set is ignored.
  - COOLDOWN: any flag set→ALARM. Otherwise after ESC_CYCLES cycles→IDLE.
  - The escalation counter is DW-independent, sized to ESC_CYCLES, and saturates.
- Priority when events coincide:
  - clr beats everything.
  - ALARM entry beats WARN entry.
  - In COOLDOWN, a flag set on the same cycle as expiry returns the FSM to ALARM.

## Timing
- T_flag changes 1 cycle after the sample_en edge, i.e. it is registered at capture.
- bcd and bcd_valid appear DW+1 cycles after the sample_en edge. busy is high for DW+1 cycles.
- Back-to-back samples: the earliest accepted next sample_en is the cycle bcd_valid is high (busy=0 in that cycle).
- H_flag rises DEB cycles after hu rises, when hu stays stable.
- The FSM reacts 1 cycle after a flag changes. warning, alarm and status change in the same cycle as the state.
- WARN→ALARM escalation happens exactly ESC_CYCLES cycles after WARN entry.
- COOLDOWN→IDLE happens exactly ESC_CYCLES cycles after ack is accepted.

## Test plan
- Defaults, temp_in=127 with sample_en pulse:
  - T_flag=1 one cycle later.
  - bcd=16'h0127 and bcd_valid pulse 8 cycles after sample_en.
  - A second sample_en 3 cycles later is ignored.
- Hysteresis:
  - Samples 35, 33, 31 → T_flag goes 1, 1, 0.
  - Sample 33 from reset → T_flag stays 0.
- Debounce, DEB=3:
  - hu pulses of 2 cycles → H_flag stays 0.
  - hu high for 3 cycles → H_flag=1.
  - hu low for 2 cycles, then high again → H_flag stays 1.
- Escalation:
  - Only H_flag set → WARN (status 0010).
  - After 16 cycles → ALARM (0100, alarm=1).
  - ack held while H_flag=1 → stays ALARM.
- Acknowledge/cooldown:
  - Clear both flags, ack=1 → COOLDOWN (1000).
  - Set T_flag in cycle 5 of COOLDOWN → ALARM.
  - Repeat without T_flag → IDLE after 16 cycles.
- Reset mid-conversion and in ALARM:
  - clr=1 → next edge gives busy=0, bcd=0, status=0001, all flags 0.
  - No bcd_valid pulse afterwards.

Source files
------------

// File: rtl/env_monitor_gen.sv
// env_monitor_gen: environment-monitor core for the temperature/humidity alarm panel.
// Captures a temperature sample, applies hysteresis thresholds, and converts the
// sample to four BCD digits with a bit-serial double-dabble engine. It also
// debounces the humidity contact. A warning/alarm FSM with timed escalation and
// acknowledge drives the panel LEDs.
module env_monitor_gen #(
  parameter int DW         = 7,
  parameter int DEB        = 3,
  parameter int TEMP_HI    = 35,
  parameter int TEMP_LO    = 32,
  parameter int ESC_CYCLES = 16
) (
  input  logic          clock,
  input  logic          clr,
  input  logic [DW-1:0] temp_in,
  input  logic          sample_en,
  input  logic          hu,
  input  logic          ack,
  output logic          T_flag,
  output logic          H_flag,
  output logic          warning,
  output logic          alarm,
  output logic [3:0]    status,
  output logic [15:0]   bcd,
  output logic          bcd_valid,
  output logic          busy
);

  localparam int CNT_W = $clog2(DW + 1);
  localparam int DEB_W = (DEB > 1) ? $clog2(DEB) : 1;
  localparam int ESC_W = (ESC_CYCLES > 1) ? $clog2(ESC_CYCLES) : 1;

  localparam logic [CNT_W-1:0] DW_LAST  = CNT_W'(DW);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB - 1);
  localparam logic [ESC_W-1:0] ESC_LAST = ESC_W'(ESC_CYCLES - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WARN     = 2'd1;
  localparam logic [1:0] ST_ALARM    = 2'd2;
  localparam logic [1:0] ST_COOLDOWN = 2'd3;

  // Converter state: shift_q doubles as the captured sample register
  logic [DW-1:0]    shift_q, shift_d;
  logic [15:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [15:0]      bcd_q, bcd_d;
  logic             bcd_valid_q, bcd_valid_d;
  logic             t_flag_q, t_flag_d;

  // Debounce state
  logic             h_flag_q, h_flag_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

  // FSM state
  logic [1:0]       state_q, state_d;
  logic [ESC_W-1:0] esc_cnt_q, esc_cnt_d;

  logic [15:0]      acc_adj;
  logic [15:0]      step_acc;
  logic [DW-1:0]    step_shift;
  logic [31:0]      temp_ext;

  assign temp_ext = 32'(temp_in);

  // One double-dabble iteration: add 3 to every digit >= 5, then shift in the next sample bit
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 4; i++) begin
      if (acc_adj[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_adj[4*i +: 4] + 4'd3;
      end
    end
    step_acc   = {acc_adj[14:0], shift_q[DW-1]};
    step_shift = {shift_q[DW-2:0], 1'b0};
  end

  // Capture, hysteresis and conversion sequencing; a capture is only taken while idle
  always_comb begin
    shift_d     = shift_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    bcd_d       = bcd_q;
    bcd_valid_d = 1'b0;
    t_flag_d    = t_flag_q;
    if (sample_en && !busy_q) begin
      shift_d = temp_in;
      acc_d   = 16'd0;
      cnt_d   = '0;
      busy_d  = 1'b1;
      if (temp_ext >= 32'(TEMP_HI)) begin
        t_flag_d = 1'b1;
      end else if (temp_ext < 32'(TEMP_LO)) begin
        t_flag_d = 1'b0;
      end
    end else if (busy_q) begin
      if (cnt_q == DW_LAST) begin
        bcd_d       = acc_q;
        bcd_valid_d = 1'b1;
        busy_d      = 1'b0;
      end else begin
        shift_d = step_shift;
        acc_d   = step_acc;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  // Humidity debounce: toggle the flag after DEB consecutive cycles of disagreement
  always_comb begin
    h_flag_d  = h_flag_q;
    deb_cnt_d = '0;
    if (hu != h_flag_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        h_flag_d = hu;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  // Warning/alarm FSM; the escalation counter is shared by WARN and COOLDOWN and clears on entry
  always_comb begin
    state_d   = state_q;
    esc_cnt_d = esc_cnt_q;
    case (state_q)
      ST_IDLE: begin
        esc_cnt_d = '0;
        if (t_flag_q && h_flag_q) begin
          state_d = ST_ALARM;
        end else if (t_flag_q ^ h_flag_q) begin
          state_d = ST_WARN;
        end
      end
      ST_WARN: begin
        if (t_flag_q && h_flag_q) begin
          state_d = ST_ALARM;
        end else if (!t_flag_q && !h_flag_q) begin
          state_d = ST_IDLE;
        end else if (esc_cnt_q == ESC_LAST) begin
          state_d = ST_ALARM;
        end else begin
          esc_cnt_d = esc_cnt_q + ESC_W'(1);
        end
      end
      ST_ALARM: begin
        esc_cnt_d = '0;
        if (ack && !t_flag_q && !h_flag_q) begin
          state_d = ST_COOLDOWN;
        end
      end
      ST_COOLDOWN: begin
        if (t_flag_q || h_flag_q) begin
          state_d = ST_ALARM;
        end else if (esc_cnt_q == ESC_LAST) begin
          state_d = ST_IDLE;
        end else begin
          esc_cnt_d = esc_cnt_q + ESC_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        esc_cnt_d = '0;
      end
    endcase
  end

  // State registers with synchronous clear
  always_ff @(posedge clock) begin
    if (clr) begin
      shift_q     <= '0;
      acc_q       <= 16'd0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      bcd_q       <= 16'd0;
      bcd_valid_q <= 1'b0;
      t_flag_q    <= 1'b0;
      h_flag_q    <= 1'b0;
      deb_cnt_q   <= '0;
      state_q     <= ST_IDLE;
      esc_cnt_q   <= '0;
    end else begin
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
      t_flag_q    <= t_flag_d;
      h_flag_q    <= h_flag_d;
      deb_cnt_q   <= deb_cnt_d;
      state_q     <= state_d;
      esc_cnt_q   <= esc_cnt_d;
    end
  end

  assign T_flag    = t_flag_q;
  assign H_flag    = h_flag_q;
  assign busy      = busy_q;
  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;
  assign warning   = (state_q == ST_WARN);
  assign alarm     = (state_q == ST_ALARM);
  assign status    = {state_q == ST_COOLDOWN, state_q == ST_ALARM,
                      state_q == ST_WARN, state_q == ST_IDLE};

endmodule

// File: tb/tb_env_monitor_gen.sv
// Directed testbench for env_monitor_gen at default parameters.
module tb_env_monitor_gen;

  logic        clock;
  logic        clr;
  logic [6:0]  temp_in;
  logic        sample_en;
  logic        hu;
  logic        ack;
  logic        T_flag;
  logic        H_flag;
  logic        warning;
  logic        alarm;
  logic [3:0]  status;
  logic [15:0] bcd;
  logic        bcd_valid;
  logic        busy;

  int vectors;
  int miscompares;

  env_monitor_gen dut (
    .clock     (clock),
    .clr       (clr),
    .temp_in   (temp_in),
    .sample_en (sample_en),
    .hu        (hu),
    .ack       (ack),
    .T_flag    (T_flag),
    .H_flag    (H_flag),
    .warning   (warning),
    .alarm     (alarm),
    .status    (status),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(negedge clock);
  endtask

  task automatic do_reset();
    clr       = 1'b1;
    sample_en = 1'b0;
    temp_in   = 7'd0;
    hu        = 1'b0;
    ack       = 1'b0;
    step();
    step();
    clr = 1'b0;
  endtask

  // Waits for the converter to go idle, then pulses sample_en; returns one falling edge after capture
  task automatic drive_sample(input logic [6:0] val);
    int guard;
    guard = 0;
    while (busy && guard < 40) begin
      step();
      guard++;
    end
    vectors++;
    if (busy) begin
      miscompares++;
      $display("[TB] FAIL busy_timeout: busy=%b required 0", busy);
    end
    temp_in   = val;
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({T_flag, H_flag, warning, alarm, status, bcd, bcd_valid, busy} !== {4'b0000, 4'b0001, 16'h0000, 2'b00}) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got T=%b H=%b w=%b a=%b st=%b bcd=%h v=%b busy=%b required all 0, st=0001",
               T_flag, H_flag, warning, alarm, status, bcd, bcd_valid, busy);
    end
  endtask

  task automatic test_conversion();
    do_reset();
    temp_in   = 7'd127;
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
    vectors++;
    if (T_flag !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL conv_tflag: got %b required 1", T_flag);
    end
    for (int k = 1; k <= 8; k++) begin
      vectors++;
      if (bcd_valid !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL conv_running k=%0d: got valid=%b busy=%b required 0/1", k, bcd_valid, busy);
      end
      if (k == 3) begin
        temp_in   = 7'd5;
        sample_en = 1'b1;
      end else begin
        sample_en = 1'b0;
      end
      step();
    end
    vectors++;
    if (bcd_valid !== 1'b1 || bcd !== 16'h0127 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL conv_done: got valid=%b bcd=%h busy=%b required 1/0127/0", bcd_valid, bcd, busy);
    end
    vectors++;
    if (T_flag !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL conv_ignored_sample: T_flag=%b required 1", T_flag);
    end
  endtask

  task automatic test_back_to_back();
    // Continues from the bcd_valid cycle of test_conversion
    temp_in   = 7'd45;
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
    vectors++;
    if (busy !== 1'b1 || bcd_valid !== 1'b0 || bcd !== 16'h0127) begin
      miscompares++;
      $display("[TB] FAIL b2b_accept: got busy=%b valid=%b bcd=%h required 1/0/0127", busy, bcd_valid, bcd);
    end
    for (int k = 2; k <= 8; k++) begin
      step();
      vectors++;
      if (bcd_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL b2b_early_valid k=%0d: got %b required 0", k, bcd_valid);
      end
    end
    step();
    vectors++;
    if (bcd_valid !== 1'b1 || bcd !== 16'h0045) begin
      miscompares++;
      $display("[TB] FAIL b2b_done: got valid=%b bcd=%h required 1/0045", bcd_valid, bcd);
    end
    step();
    vectors++;
    if (bcd_valid !== 1'b0 || bcd !== 16'h0045) begin
      miscompares++;
      $display("[TB] FAIL b2b_hold: got valid=%b bcd=%h required 0/0045", bcd_valid, bcd);
    end
  endtask

  task automatic test_hysteresis();
    logic [6:0] samples [7];
    logic       expect_t [7];
    samples  = '{7'd35, 7'd33, 7'd31, 7'd32, 7'd35, 7'd32, 7'd31};
    expect_t = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive_sample(samples[i]);
      vectors++;
      if (T_flag !== expect_t[i]) begin
        miscompares++;
        $display("[TB] FAIL hyst_%0d sample=%0d: T_flag=%b required %b", i, samples[i], T_flag, expect_t[i]);
      end
    end
    do_reset();
    drive_sample(7'd33);
    vectors++;
    if (T_flag !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hyst_from_reset: T_flag=%b required 0", T_flag);
    end
  endtask

  task automatic test_debounce();
    logic hu_seq [15];
    logic h_exp  [15];
    // hu driven at each falling edge, H_flag required at the following falling edge
    hu_seq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    h_exp  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 15; i++) begin
      hu = hu_seq[i];
      step();
      vectors++;
      if (H_flag !== h_exp[i]) begin
        miscompares++;
        $display("[TB] FAIL debounce_%0d: H_flag=%b required %b", i, H_flag, h_exp[i]);
      end
    end
  endtask

  task automatic test_escalation();
    do_reset();
    hu = 1'b1;
    step();
    step();
    step();
    vectors++;
    if (H_flag !== 1'b1 || status !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL esc_hflag: H=%b st=%b required 1/0001", H_flag, status);
    end
    step();
    vectors++;
    if (status !== 4'b0010 || warning !== 1'b1 || alarm !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL esc_warn_entry: st=%b w=%b a=%b required 0010/1/0", status, warning, alarm);
    end
    for (int k = 5; k <= 19; k++) begin
      step();
      vectors++;
      if (status !== 4'b0010) begin
        miscompares++;
        $display("[TB] FAIL esc_warn_hold k=%0d: st=%b required 0010", k, status);
      end
    end
    step();
    vectors++;
    if (status !== 4'b0100 || alarm !== 1'b1 || warning !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL esc_alarm: st=%b a=%b w=%b required 0100/1/0", status, alarm, warning);
    end
    ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if (status !== 4'b0100) begin
        miscompares++;
        $display("[TB] FAIL esc_ack_ignored k=%0d: st=%b required 0100", k, status);
      end
    end
  endtask

  task automatic test_cooldown();
    // Continues from ALARM with ack held and hu high
    hu = 1'b0;
    step();
    step();
    step();
    vectors++;
    if (H_flag !== 1'b0 || status !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL cool_hfall: H=%b st=%b required 0/0100", H_flag, status);
    end
    step();
    ack = 1'b0;
    vectors++;
    if (status !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL cool_entry: st=%b required 1000", status);
    end
    for (int k = 0; k < 4; k++) step();
    drive_sample(7'd40);
    vectors++;
    if (T_flag !== 1'b1 || status !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL cool_tset: T=%b st=%b required 1/1000", T_flag, status);
    end
    step();
    vectors++;
    if (status !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL cool_realarm: st=%b required 0100", status);
    end
    drive_sample(7'd10);
    vectors++;
    if (T_flag !== 1'b0 || status !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL cool_tclear: T=%b st=%b required 0/0100", T_flag, status);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    vectors++;
    if (status !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL cool_entry2: st=%b required 1000", status);
    end
    for (int k = 1; k <= 15; k++) begin
      step();
      vectors++;
      if (status !== 4'b1000) begin
        miscompares++;
        $display("[TB] FAIL cool_hold k=%0d: st=%b required 1000", k, status);
      end
    end
    step();
    vectors++;
    if (status !== 4'b0001 || alarm !== 1'b0 || warning !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL cool_expire: st=%b a=%b w=%b required 0001/0/0", status, alarm, warning);
    end
  endtask

  task automatic test_reset_midway();
    do_reset();
    hu = 1'b1;
    drive_sample(7'd100);
    step();
    step();
    step();
    vectors++;
    if (status !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL rst_setup_alarm: st=%b required 0100", status);
    end
    drive_sample(7'd99);
    step();
    step();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rst_setup_busy: busy=%b required 1", busy);
    end
    clr = 1'b1;
    hu  = 1'b0;
    step();
    clr = 1'b0;
    vectors++;
    if ({T_flag, H_flag, warning, alarm, status, bcd, bcd_valid, busy} !== {4'b0000, 4'b0001, 16'h0000, 2'b00}) begin
      miscompares++;
      $display("[TB] FAIL rst_mid: got T=%b H=%b w=%b a=%b st=%b bcd=%h v=%b busy=%b required all 0, st=0001",
               T_flag, H_flag, warning, alarm, status, bcd, bcd_valid, busy);
    end
    for (int k = 0; k < 15; k++) begin
      step();
      vectors++;
      if (bcd_valid !== 1'b0 || busy !== 1'b0 || bcd !== 16'h0000) begin
        miscompares++;
        $display("[TB] FAIL rst_no_valid k=%0d: v=%b busy=%b bcd=%h required 0/0/0000", k, bcd_valid, busy, bcd);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clr         = 1'b1;
    sample_en   = 1'b0;
    temp_in     = 7'd0;
    hu          = 1'b0;
    ack         = 1'b0;
    step();
    test_reset();
    test_conversion();
    test_back_to_back();
    test_hysteresis();
    test_debounce();
    test_escalation();
    test_cooldown();
    test_reset_midway();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
